mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, grant encoding, streak width.
// No logic; no latency.
// No flow control of its own; the arbiter holds requesters until their ack.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } gnt_t;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Picks the next memory-port winner from the two requests and the CPU streak count.
// Purely combinational, zero latency.
// No backpressure; vld only says whether anyone is asking.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic                cpu_req,
    input  logic                dma_req,
    input  logic [STREAK_W-1:0] streak,
    output gnt_t                gnt,
    output logic                vld
);

    always_comb begin
        vld = cpu_req | dma_req;
        gnt = GNT_CPU;
        // CPU has priority until it has starved a waiting DMA for MAX_CPU_STREAK grants
        if (dma_req && (!cpu_req || streak == STREAK_W'(MAX_CPU_STREAK))) begin
            gnt = GNT_DMA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between a CPU port and a DMA/debug port.
// Latency: req to ack is MEM_LAT+2 cycles; one access per MEM_LAT+3 cycles.
// Backpressure: requesters hold req/we/addr/wdata until they see their ack pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MEM_LAT        = 2,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t              state_q,     state_d;
    gnt_t                gnt_q,       gnt_d;
    logic [2:0]          cnt_q,       cnt_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [AW-1:0]       mem_addr_q,  mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic                cpu_ack_q,   cpu_ack_d;
    logic                dma_ack_q,   dma_ack_d;
    logic [DW-1:0]       cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]       dma_rdata_q, dma_rdata_d;

    gnt_t pick_gnt;
    logic pick_vld;

    mem_arb_pick #(
        .MAX_CPU_STREAK(MAX_CPU_STREAK)
    ) u_pick (
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .streak  (streak_q),
        .gnt     (pick_gnt),
        .vld     (pick_vld)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        case (state_q)
            IDLE: begin
                if (!dma_req) begin
                    streak_d = '0;
                end
                if (pick_vld) begin
                    gnt_d    = pick_gnt;
                    mem_en_d = 1'b1;
                    state_d  = ISSUE;
                    if (pick_gnt == GNT_DMA) begin
                        mem_we_d    = dma_we;
                        mem_addr_d  = dma_addr;
                        mem_wdata_d = dma_wdata;
                        streak_d    = '0;
                    end else begin
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        if (dma_req && streak_q != STREAK_W'(MAX_CPU_STREAK)) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                cnt_d   = 3'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    // read data is valid on this final WAIT edge
                    if (gnt_q == GNT_DMA) begin
                        dma_ack_d = 1'b1;
                        if (!mem_we_q) dma_rdata_d = mem_rdata;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!mem_we_q) cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_CPU;
            cnt_q       <= '0;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule
